universal_shift_register: RTL and testbench



---
 rtl/universal_shift_register.sv | 171 +++++++++++++++++
 tb/tb_universal_shift_register.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// ---------------------------------------------------------------------------
// universal_shift_register
//
// WIDTH-bit storage register with hold, shift-right, shift-left and parallel
// load. Operations are applied either one at a time (Enable, IDLE only) or as
// a burst of Count consecutive operations started by Start. A burst is
// tracked by a small IDLE/RUN/DONE state machine that reports Busy while
// running and a one-cycle Done pulse at the end.
//
// Optional build macro: USR_ROTATE_EN
//   Adds input Rotate. With Rotate=1 the shifts recirculate the bit leaving
//   the register instead of taking the serial inputs. Rotate is latched with
//   Start for bursts and used live for single steps.
//
// Ports:
//   Clk              clock, all state changes on the rising edge
//   Reset_n          synchronous active-low reset
//   Mode             00 hold, 01 shift right, 10 shift left, 11 load
//   Enable           single-step request (IDLE only)
//   Load_data        parallel load value (sampled live, also during bursts)
//   Serial_in_left   bit entering the MSB on shift right
//   Serial_in_right  bit entering the LSB on shift left
//   Start            burst request (IDLE only), wins over Enable
//   Count            burst length, sampled with Start
//   Rotate           (USR_ROTATE_EN only) rotate instead of serial shift
//   Q                register contents
//   Serial_out_left  Q[WIDTH-1]
//   Serial_out_right Q[0]
//   Busy             high while a burst is running
//   Done             one-cycle pulse after a burst (or a zero-length burst)
// ---------------------------------------------------------------------------
module universal_shift_register #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [1:0]           Mode,
    input  logic                 Enable,
    input  logic [WIDTH-1:0]     Load_data,
    input  logic                 Serial_in_left,
    input  logic                 Serial_in_right,
    input  logic                 Start,
    input  logic [CNT_WIDTH-1:0] Count,
`ifdef USR_ROTATE_EN
    input  logic                 Rotate,
`endif
    output logic [WIDTH-1:0]     Q,
    output logic                 Serial_out_left,
    output logic                 Serial_out_right,
    output logic                 Busy,
    output logic                 Done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_r, state_s;
    logic [CNT_WIDTH-1:0] cnt_r,   cnt_s;
    logic [1:0]           mode_r,  mode_s;
    logic                 rot_r,   rot_s;
    logic [WIDTH-1:0]     q_r,     q_s;
    logic                 busy_r;
    logic                 done_r;
    logic                 rot_live_s;

    // Next register value for one operation; rot selects recirculation.
    function automatic logic [WIDTH-1:0] apply_op(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] ld,
        input logic             sil,
        input logic             sir,
        input logic             rot
    );
        logic [WIDTH-1:0] res;
        case (op)
            2'b00:   res = cur;
            2'b01:   res = {(rot ? cur[0] : sil), cur[WIDTH-1:1]};
            2'b10:   res = {cur[WIDTH-2:0], (rot ? cur[WIDTH-1] : sir)};
            2'b11:   res = ld;
            default: res = cur;
        endcase
        return res;
    endfunction

`ifdef USR_ROTATE_EN
    assign rot_live_s = Rotate;
`else
    assign rot_live_s = 1'b0;
`endif

    // Next-state, counter, latched-command and data-path selection.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        mode_s  = mode_r;
        rot_s   = rot_r;
        q_s     = q_r;
        case (state_r)
            S_IDLE: begin
                if (Start) begin
                    // A burst request takes the edge; no operation happens now.
                    if (Count != {CNT_WIDTH{1'b0}}) begin
                        mode_s  = Mode;
                        cnt_s   = Count;
                        rot_s   = rot_live_s;
                        state_s = S_RUN;
                    end else begin
                        state_s = S_DONE;
                    end
                end else if (Enable) begin
                    q_s = apply_op(Mode, q_r, Load_data, Serial_in_left,
                                   Serial_in_right, rot_live_s);
                end else begin
                    q_s = q_r;
                end
            end
            S_RUN: begin
                q_s   = apply_op(mode_r, q_r, Load_data, Serial_in_left,
                                 Serial_in_right, rot_r);
                cnt_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State and data registers; Busy/Done are registered from the next state
    // so they line up with the state they describe and can never overlap.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r <= S_IDLE;
            cnt_r   <= {CNT_WIDTH{1'b0}};
            mode_r  <= 2'b00;
            rot_r   <= 1'b0;
            q_r     <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            mode_r  <= mode_s;
            rot_r   <= rot_s;
            q_r     <= q_s;
            busy_r  <= (state_s == S_RUN);
            done_r  <= (state_s == S_DONE);
        end
    end

    assign Q                = q_r;
    assign Serial_out_left  = q_r[WIDTH-1];
    assign Serial_out_right = q_r[0];
    assign Busy             = busy_r;
    assign Done             = done_r;

endmodule

// File: tb/tb_universal_shift_register.sv
// ---------------------------------------------------------------------------
// Self-checking bench for universal_shift_register (WIDTH=8, CNT_WIDTH=4).
// Expected values come from an arithmetic reference model of the register
// operations plus directed constants for the documented scenarios.
// ---------------------------------------------------------------------------
module tb_universal_shift_register;

`ifdef USR_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic       Clk;
    logic       Reset_n;
    logic [1:0] Mode;
    logic       Enable;
    logic [7:0] Load_data;
    logic       Serial_in_left;
    logic       Serial_in_right;
    logic       Start;
    logic [3:0] Count;
    logic       Rotate;
    logic [7:0] Q;
    logic       Serial_out_left;
    logic       Serial_out_right;
    logic       Busy;
    logic       Done;

    int total = 0;
    int bad   = 0;
    logic [7:0] q_m;

    universal_shift_register #(.WIDTH(8), .CNT_WIDTH(4)) dut (
        .Clk              (Clk),
        .Reset_n          (Reset_n),
        .Mode             (Mode),
        .Enable           (Enable),
        .Load_data        (Load_data),
        .Serial_in_left   (Serial_in_left),
        .Serial_in_right  (Serial_in_right),
        .Start            (Start),
        .Count            (Count),
`ifdef USR_ROTATE_EN
        .Rotate           (Rotate),
`endif
        .Q                (Q),
        .Serial_out_left  (Serial_out_left),
        .Serial_out_right (Serial_out_right),
        .Busy             (Busy),
        .Done             (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference: one operation computed with plain integer arithmetic.
    function automatic logic [7:0] model_op(input int md, input logic [7:0] q,
                                            input logic [7:0] ld, input bit sil,
                                            input bit sir, input bit rot);
        int v;
        int ins;
        v = int'(q);
        case (md)
            1: begin
                ins = rot ? (v % 2) : int'(sil);
                return 8'((v / 2) + ins * 128);
            end
            2: begin
                ins = rot ? (v / 128) : int'(sir);
                return 8'((v * 2 + ins) % 256);
            end
            3: return ld;
            default: return q;
        endcase
    endfunction

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Load a value through a single step and keep the model in sync.
    task automatic preload(input logic [7:0] v);
        Start = 1'b0; Enable = 1'b1; Mode = 2'b11; Load_data = v;
        tick;
        Enable = 1'b0; Mode = 2'b00;
        q_m = v;
    endtask

    task automatic test_reset;
        Reset_n = 1'b0;
        tick; tick;
        q_m = 8'h00;
        total++;
        if ({Q, Busy, Done} !== {8'h00, 1'b0, 1'b0}) begin
            bad++; $display("FAIL reset_init got Q=%h B=%b D=%b want 00 0 0", Q, Busy, Done);
        end
        Reset_n = 1'b1;
        preload(8'h5A);
        #3 Reset_n = 1'b0;
        #1;
        total++;
        if (Q !== 8'h5A) begin
            bad++; $display("FAIL reset_midcycle got Q=%h want 5a", Q);
        end
        tick;
        q_m = 8'h00;
        total++;
        if ({Q, Busy, Done} !== {8'h00, 1'b0, 1'b0}) begin
            bad++; $display("FAIL reset_edge got Q=%h B=%b D=%b want 00 0 0", Q, Busy, Done);
        end
        Reset_n = 1'b1;
    endtask

    task automatic test_single_step;
        Enable = 1'b1; Mode = 2'b11; Load_data = 8'hA5;
        tick;
        total++;
        if (Q !== 8'hA5) begin
            bad++; $display("FAIL step_load got Q=%h want a5", Q);
        end
        Mode = 2'b01; Serial_in_left = 1'b1;
        tick;
        q_m = 8'hD2;
        total++;
        if ({Q, Serial_out_left, Serial_out_right} !== {8'hD2, 1'b1, 1'b0}) begin
            bad++; $display("FAIL step_shr got Q=%h SOL=%b SOR=%b want d2 1 0",
                            Q, Serial_out_left, Serial_out_right);
        end
        for (int i = 0; i < 40; i++) begin
            Mode = 2'($urandom); Enable = 1'($urandom);
            Load_data = 8'($urandom);
            Serial_in_left = 1'($urandom); Serial_in_right = 1'($urandom);
            Rotate = ROT_EN ? 1'($urandom) : 1'b0;
            tick;
            if (Enable)
                q_m = model_op(int'(Mode), q_m, Load_data, Serial_in_left,
                               Serial_in_right, ROT_EN && Rotate);
            total++;
            if ({Q, Busy, Done, Serial_out_left, Serial_out_right} !==
                {q_m, 1'b0, 1'b0, q_m[7], q_m[0]}) begin
                bad++; $display("FAIL step_rand[%0d] got Q=%h B=%b D=%b SOL=%b SOR=%b want Q=%h",
                                i, Q, Busy, Done, Serial_out_left, Serial_out_right, q_m);
            end
        end
        Enable = 1'b0; Rotate = 1'b0;
    endtask

    task automatic test_burst;
        logic [7:0] exp_q [3];
        exp_q[0] = 8'h02; exp_q[1] = 8'h04; exp_q[2] = 8'h08;
        preload(8'h81);
        Start = 1'b1; Mode = 2'b10; Count = 4'd3; Serial_in_right = 1'b0;
        tick;
        total++;
        if ({Q, Busy, Done} !== {8'h81, 1'b1, 1'b0}) begin
            bad++; $display("FAIL burst_start got Q=%h B=%b D=%b want 81 1 0", Q, Busy, Done);
        end
        for (int k = 0; k < 3; k++) begin
            // Stray Start/Mode/Enable while running must be ignored.
            Start = (k == 0); Mode = 2'b01; Count = 4'd7; Enable = (k == 1);
            tick;
            total++;
            if ({Q, Busy, Done} !== {exp_q[k], (k < 2), (k == 2)}) begin
                bad++; $display("FAIL burst_run[%0d] got Q=%h B=%b D=%b want %h %b %b",
                                k, Q, Busy, Done, exp_q[k], (k < 2), (k == 2));
            end
        end
        Start = 1'b0; Enable = 1'b0; Mode = 2'b00;
        tick;
        q_m = 8'h08;
        total++;
        if ({Q, Busy, Done} !== {8'h08, 1'b0, 1'b0}) begin
            bad++; $display("FAIL burst_idle got Q=%h B=%b D=%b want 08 0 0", Q, Busy, Done);
        end
    endtask

    task automatic test_zero_count;
        Start = 1'b1; Count = 4'd0; Mode = 2'b11; Load_data = 8'hFF;
        tick;
        Start = 1'b0;
        total++;
        if ({Q, Busy, Done} !== {q_m, 1'b0, 1'b1}) begin
            bad++; $display("FAIL zero_done got Q=%h B=%b D=%b want %h 0 1", Q, Busy, Done, q_m);
        end
        tick;
        total++;
        if ({Q, Busy, Done} !== {q_m, 1'b0, 1'b0}) begin
            bad++; $display("FAIL zero_after got Q=%h B=%b D=%b want %h 0 0", Q, Busy, Done, q_m);
        end
    endtask

    task automatic test_reset_midburst;
        preload(8'h3C);
        Start = 1'b1; Mode = 2'b01; Count = 4'd5; Serial_in_left = 1'b1;
        tick;
        Start = 1'b0;
        tick;
        tick;
        total++;
        if ({Q, Busy, Done} !== {8'hCF, 1'b1, 1'b0}) begin
            bad++; $display("FAIL midrst_run got Q=%h B=%b D=%b want cf 1 0", Q, Busy, Done);
        end
        Reset_n = 1'b0;
        tick;
        total++;
        if ({Q, Busy, Done} !== {8'h00, 1'b0, 1'b0}) begin
            bad++; $display("FAIL midrst_rst got Q=%h B=%b D=%b want 00 0 0", Q, Busy, Done);
        end
        Reset_n = 1'b1;
        tick;
        total++;
        if ({Q, Busy, Done} !== {8'h00, 1'b0, 1'b0}) begin
            bad++; $display("FAIL midrst_nodone got Q=%h B=%b D=%b want 00 0 0", Q, Busy, Done);
        end
        Start = 1'b1; Count = 4'd2; Mode = 2'b11; Load_data = 8'h77;
        tick;
        Start = 1'b0;
        total++;
        if ({Q, Busy, Done} !== {8'h00, 1'b1, 1'b0}) begin
            bad++; $display("FAIL midrst_restart got Q=%h B=%b D=%b want 00 1 0", Q, Busy, Done);
        end
        tick; tick; tick;
        q_m = 8'h77;
        total++;
        if ({Q, Busy, Done} !== {8'h77, 1'b0, 1'b0}) begin
            bad++; $display("FAIL midrst_end got Q=%h B=%b D=%b want 77 0 0", Q, Busy, Done);
        end
    endtask

    task automatic test_random_bursts;
        int md;
        int n;
        bit rot;
        for (int b = 0; b < 12; b++) begin
            md  = int'($urandom_range(0, 3));
            n   = (b % 4 == 3) ? 0 : int'($urandom_range(1, 15));
            rot = ROT_EN && ($urandom_range(0, 1) == 1);
            Start = 1'b1; Mode = 2'(md); Count = 4'(n); Rotate = rot;
            Enable = 1'b1;
            tick;
            total++;
            if ({Q, Busy, Done} !== {q_m, (n != 0), (n == 0)}) begin
                bad++; $display("FAIL rb_start[%0d] got Q=%h B=%b D=%b want %h %b %b",
                                b, Q, Busy, Done, q_m, (n != 0), (n == 0));
            end
            for (int k = 1; k <= n; k++) begin
                Load_data = 8'($urandom);
                Serial_in_left = 1'($urandom); Serial_in_right = 1'($urandom);
                Mode = 2'($urandom); Start = 1'($urandom); Enable = 1'($urandom);
                Count = 4'($urandom); Rotate = 1'($urandom);
                tick;
                q_m = model_op(md, q_m, Load_data, Serial_in_left, Serial_in_right, rot);
                total++;
                if ({Q, Busy, Done} !== {q_m, (k < n), (k == n)}) begin
                    bad++; $display("FAIL rb_run[%0d.%0d] got Q=%h B=%b D=%b want %h %b %b",
                                    b, k, Q, Busy, Done, q_m, (k < n), (k == n));
                end
            end
            // Requests during the DONE cycle are dropped.
            Start = 1'b1; Enable = 1'b1; Mode = 2'b11; Count = 4'd4;
            Load_data = ~q_m;
            tick;
            total++;
            if ({Q, Busy, Done} !== {q_m, 1'b0, 1'b0}) begin
                bad++; $display("FAIL rb_done_ign[%0d] got Q=%h B=%b D=%b want %h 0 0",
                                b, Q, Busy, Done, q_m);
            end
            Start = 1'b0; Enable = 1'b0; Rotate = 1'b0;
        end
    endtask

`ifdef USR_ROTATE_EN
    task automatic test_rotate;
        preload(8'h81);
        Enable = 1'b1; Mode = 2'b01; Rotate = 1'b1; Serial_in_left = 1'b0;
        tick;
        total++;
        if (Q !== 8'hC0) begin
            bad++; $display("FAIL rot_right got Q=%h want c0", Q);
        end
        preload(8'h81);
        Enable = 1'b1; Mode = 2'b10; Rotate = 1'b1; Serial_in_right = 1'b0;
        tick;
        total++;
        if (Q !== 8'h03) begin
            bad++; $display("FAIL rot_left got Q=%h want 03", Q);
        end
        q_m = 8'h03;
        Enable = 1'b0; Start = 1'b1; Mode = 2'b10; Count = 4'd4; Rotate = 1'b1;
        tick;
        Start = 1'b0; Rotate = 1'b0;
        tick; tick; tick; tick;
        total++;
        if ({Q, Busy, Done} !== {8'h30, 1'b0, 1'b1}) begin
            bad++; $display("FAIL rot_burst got Q=%h B=%b D=%b want 30 0 1", Q, Busy, Done);
        end
        tick;
        q_m = 8'h30;
    endtask
`endif

    initial begin
        Reset_n = 1'b0; Mode = 2'b00; Enable = 1'b0; Load_data = 8'h00;
        Serial_in_left = 1'b0; Serial_in_right = 1'b0; Start = 1'b0;
        Count = 4'd0; Rotate = 1'b0; q_m = 8'h00;
        test_reset;
        test_single_step;
        test_burst;
        test_zero_count;
        test_reset_midburst;
        test_random_bursts;
`ifdef USR_ROTATE_EN
        test_rotate;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
